serial_add_unit: RTL
====================

// Module: serial_add_unit
//
// PURPOSE
// - Bit-serial adder/reconstructor, the inverse of the half-subtractor datapath: recovers a = diff + b.
// - Takes WIDTH-bit difference and subtrahend operands, processes them LSB-first, one bit per clock, through a single full-adder cell.
// - Returns a WIDTH-bit sum and a carry-out.
// - Sits beside the subtractor blocks as the arithmetic check/restore path for lab-level datapaths.
//
// PARAMETERS
// - WIDTH  8  operand/result width in bits; legal range 2..32.
//
// PORTS
// - i_clk    input   1      single clock; all logic on rising edge.
// - i_rst    input   1      reset, synchronous, active-high.
// - i_start  input   1      request; sampled only in IDLE.
// - i_diff   input   WIDTH  difference operand; captured on the start edge.
// - i_sub    input   WIDTH  subtrahend operand; captured on the start edge.
// - o_busy   output  1      high in RUN and DONE.
// - o_done   output  1      one-cycle pulse; o_sum and o_carry are valid.
// - o_sum    output  WIDTH  (i_diff + i_sub) mod 2^WIDTH; holds until the next completion.
// - o_carry  output  1      carry out of bit WIDTH-1; holds with o_sum.
//
// BEHAVIOUR
// - Reset: state=IDLE; o_busy=0, o_done=0, o_sum=0, o_carry=0; shift registers, carry flop and counter cleared.
// - FSM states (2-bit): IDLE, RUN, DONE.
// - IDLE:
//   - On i_start=1 at edge E0: load A<=i_diff, B<=i_sub, c<=0, cnt<=0; go to RUN.
//   - On i_start=0: stay in IDLE.
// - RUN, each edge:
//   - s = A[0]^B[0]^c; c <= A[0]&B[0] | c&(A[0]^B[0]).
//   - R <= {s, R[WIDTH-1:1]}; A, B shift right by 1; cnt <= cnt+1.
//   - At the edge where cnt==WIDTH-1 (edge E0+WIDTH): o_sum <= final R, o_carry <= final c; go to DONE.
// - DONE: o_done=1 for exactly one cycle, then IDLE at the next edge.
// - Latency: o_done is high in the cycle after edge E0+WIDTH, i.e. WIDTH+1 cycles after i_start was presented.
// - i_start while busy (RUN or DONE): ignored, no queueing. Operand inputs are don't-care outside the start edge.
// - Earliest new start: the cycle after DONE (back-to-back gives a throughput of one result per WIDTH+2 cycles).
// - Reset mid-operation: aborts at the reset edge; all outputs return to reset values. No o_done for the aborted operation.
// - Reset and i_start in the same cycle: reset wins.
// - Width rules:
//   - cnt is $clog2(WIDTH) bits.
//   - Sum wraps mod 2^WIDTH; the overflow bit appears only on o_carry.
//   - Result matches the combinational i_diff + i_sub.
// - o_sum/o_carry update only on the edge entering DONE and do not glitch during RUN.
//
// STRUCTURE
// - Package serial_arith_pkg: state typedef (IDLE/RUN/DONE) and the default WIDTH constant.
// - Sub-module full_add_bit (i_a, i_b, i_cin -> o_sum, o_cout), built from two half-adder stages plus an OR gate.
//   - This cell is instantiated once for the serial bit slice.
// - The top level holds the FSM, counter, three shift registers, carry flop and output registers.
//
// TESTING  (WIDTH=8, reset asserted 2 cycles first)
// 1. i_diff=0x05, i_sub=0x03, start pulse -> o_done in the 9th cycle after start; o_sum=0x08, o_carry=0; o_busy high for 9 cycles.
// 2. i_diff=0xFF, i_sub=0x01 -> o_sum=0x00, o_carry=1. Then 0x00+0x00 -> o_sum=0x00, o_carry=0.
// 3. Start 0x10+0x20; pulse i_start with 0xAA/0x55 at cycle 4 (during RUN) -> single o_done, o_sum=0x30; second request dropped.
// 4. Start 0x7F+0x7F; assert i_rst at cycle 5 -> next cycle all outputs 0, no o_done; a later 0x01+0x01 -> o_sum=0x02.
// 5. Back-to-back: start 0x0C+0x04 (result 0x10); re-assert i_start the cycle after o_done with 0x80+0x80 -> o_sum=0x00, o_carry=1.
// 6. Random sweep of 1000 operand pairs vs. a reference model (a+b) -> exact sum/carry match; o_done exactly once per accepted start.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// +-----------------------------------------------------------------------+
// | serial_arith_pkg: shared state encoding and default width.  Rev 1.0   |
// +-----------------------------------------------------------------------+
`default_nettype none

package serial_arith_pkg;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

`default_nettype wire

// File: rtl/serial_add_unit_if.sv
// +-----------------------------------------------------------------------+
// | serial_add_unit_if: request/result bundle of the serial adder. Rev 1.0|
// +-----------------------------------------------------------------------+
`default_nettype none

interface serial_add_unit_if #(
  parameter int WIDTH = serial_arith_pkg::DEFAULT_WIDTH
);
  logic             i_start;
  logic [WIDTH-1:0] i_diff;
  logic [WIDTH-1:0] i_sub;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_sum;
  logic             o_carry;

  modport master (
    output i_start, i_diff, i_sub,
    input  o_busy, o_done, o_sum, o_carry
  );

  modport slave (
    input  i_start, i_diff, i_sub,
    output o_busy, o_done, o_sum, o_carry
  );
endinterface

`default_nettype wire

// File: rtl/full_add_bit.sv
// +-----------------------------------------------------------------------+
// | full_add_bit: one-bit full adder from two half adders and an OR.      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module full_add_bit (
  input  wire logic i_a,
  input  wire logic i_b,
  input  wire logic i_cin,
  output logic      o_sum,
  output logic      o_cout
);
  logic w_hs1_sum;
  logic w_hs1_carry;
  logic w_hs2_carry;

  assign w_hs1_sum   = i_a ^ i_b;
  assign w_hs1_carry = i_a & i_b;
  assign o_sum       = w_hs1_sum ^ i_cin;
  assign w_hs2_carry = w_hs1_sum & i_cin;
  assign o_cout      = w_hs1_carry | w_hs2_carry;
endmodule

`default_nettype wire

// File: rtl/serial_add_unit.sv
// +-----------------------------------------------------------------------+
// | serial_add_unit: bit-serial LSB-first adder, a = diff + sub.  Rev 1.0 |
// +-----------------------------------------------------------------------+
`default_nettype none

module serial_add_unit
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  wire logic         i_clk,
  input  wire logic         i_rst,
  serial_add_unit_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               c_q, c_d;
  logic               carry_q, carry_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               w_bit_sum;
  logic               w_bit_cout;

  full_add_bit u_bit_slice (
    .i_a    (a_q[0]),
    .i_b    (b_q[0]),
    .i_cin  (c_q),
    .o_sum  (w_bit_sum),
    .o_cout (w_bit_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    carry_d = carry_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          a_d     = bus.i_diff;
          b_d     = bus.i_sub;
          c_d     = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        c_d   = w_bit_cout;
        r_d   = {w_bit_sum, r_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        // Result registers load only here, so they stay steady throughout RUN.
        if (cnt_q == C_LAST) begin
          sum_d   = {w_bit_sum, r_q[WIDTH-1:1]};
          carry_d = w_bit_cout;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.o_busy  = busy_q;
  assign bus.o_done  = done_q;
  assign bus.o_sum   = sum_q;
  assign bus.o_carry = carry_q;
endmodule

`default_nettype wire
